// File: rtl/hline_zspan_engine.sv
// hline_zspan_engine: rasterises one horizontal z-buffered span in bursts of
// up to BURST_LEN pixels, with Bresenham-style z interpolation and a selectable
// depth-compare mode.
// Optional build macro HLINE_ZSTATS_EN adds saturating pass/fail pixel counters.
module hline_zspan_engine #(
    parameter int unsigned X_W       = 16,
    parameter int unsigned Z_W       = 32,
    parameter int unsigned PIX_BYTES = 2,
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned ROW_PITCH = 640
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    input  logic [31:0]                  fb_addr,
    input  logic [31:0]                  zbuff_addr,
    input  logic [X_W-1:0]               y,
    input  logic [X_W-1:0]               x1,
    input  logic [X_W-1:0]               x2,
    input  logic [Z_W-1:0]               z1,
    input  logic [Z_W-1:0]               slope,
    input  logic [Z_W-1:0]               rem,
    input  logic [Z_W-1:0]               err,
    input  logic [1:0]                   cmp_mode,
    output logic                         rd_req,
    output logic                         wr_req,
    output logic                         wr_sel,
    output logic [31:0]                  addr,
    output logic [$clog2(BURST_LEN):0]   burst_len,
    input  logic                         axi_done,
    input  logic                         zread_empty,
    input  logic [Z_W-1:0]               zfifo_in,
    output logic                         read_zfifo,
    input  logic                         zfull,
    input  logic                         befull,
    output logic                         write_zfifo,
    output logic                         write_befifo,
    output logic [Z_W-1:0]               z_out,
    output logic [PIX_BYTES-1:0]         be_out
`ifdef HLINE_ZSTATS_EN
    ,
    output logic [X_W:0]                 pass_cnt,
    output logic [X_W:0]                 fail_cnt
`endif
);

    localparam int unsigned BL_W = $clog2(BURST_LEN) + 1;
    localparam int unsigned XC_W = X_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ZRD, S_CMP, S_ZWR, S_FBWR, S_NEXT, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             rd_req_q, rd_req_d, wr_req_q, wr_req_d, wr_sel_q, wr_sel_d;
    logic [31:0]      addr_q, addr_d;
    logic [BL_W-1:0]  burst_len_q, burst_len_d;
    logic [31:0]      fb_base_q, fb_base_d, zb_base_q, zb_base_d;
    logic [31:0]      zb_burst_q, zb_burst_d, fb_burst_q, fb_burst_d;
    logic [X_W-1:0]   y_q, y_d, x2_q, x2_d, dx_q, dx_d;
    logic [Z_W-1:0]   slope_q, slope_d, rem_q, rem_d;
    logic [1:0]       mode_q, mode_d;
    logic [XC_W-1:0]  cur_x_q, cur_x_d;
    logic [Z_W-1:0]   z_cur_q, z_cur_d, e_q, e_d;
    logic [BL_W-1:0]  cnt_q, cnt_d, chunk_q, chunk_d;

    logic             push_c, pass_c, load_burst;
    logic [XC_W-1:0]  rem_px;
    logic [31:0]      pix;
    logic [Z_W-1:0]   t_c;

    // Pixel accept condition and unsigned depth test against the FIFO head
    always_comb begin
        push_c = (state_q == S_CMP) && !zread_empty && !zfull && !befull;
        case (mode_q)
            2'b00:   pass_c = (z_cur_q <  zfifo_in);
            2'b01:   pass_c = (z_cur_q <= zfifo_in);
            2'b10:   pass_c = 1'b1;
            default: pass_c = 1'b0;
        endcase
    end

    // Next-state, datapath update and registered request outputs
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rd_req_d    = 1'b0;
        wr_req_d    = 1'b0;
        wr_sel_d    = 1'b0;
        addr_d      = '0;
        burst_len_d = '0;
        fb_base_d   = fb_base_q;
        zb_base_d   = zb_base_q;
        zb_burst_d  = zb_burst_q;
        fb_burst_d  = fb_burst_q;
        y_d         = y_q;
        x2_d        = x2_q;
        dx_d        = dx_q;
        slope_d     = slope_q;
        rem_d       = rem_q;
        mode_d      = mode_q;
        cur_x_d     = cur_x_q;
        z_cur_d     = z_cur_q;
        e_d         = e_q;
        cnt_d       = cnt_q;
        chunk_d     = chunk_q;
        load_burst  = 1'b0;
        rem_px      = '0;
        pix         = '0;
        t_c         = e_q - rem_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d    = 1'b1;
                    fb_base_d = fb_addr;
                    zb_base_d = zbuff_addr;
                    y_d       = y;
                    x2_d      = x2;
                    dx_d      = x2 - x1;
                    slope_d   = slope;
                    rem_d     = rem;
                    mode_d    = cmp_mode;
                    cur_x_d   = XC_W'(x1);
                    z_cur_d   = z1;
                    e_d       = err;
                    if (x1 > x2) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_ZRD;
                        load_burst = 1'b1;
                    end
                end
            end
            S_ZRD: begin
                if (axi_done) begin
                    state_d = S_CMP;
                    cnt_d   = '0;
                end
            end
            S_CMP: begin
                if (push_c) begin
                    // Negative error term (MSB set) takes the extra unit step
                    if (t_c[Z_W-1]) begin
                        z_cur_d = z_cur_q + slope_q + Z_W'(1);
                        e_d     = t_c + Z_W'(dx_q);
                    end else begin
                        z_cur_d = z_cur_q + slope_q;
                        e_d     = t_c;
                    end
                    cur_x_d = cur_x_q + XC_W'(1);
                    if (cnt_q == chunk_q - BL_W'(1)) begin
                        state_d = S_ZWR;
                    end else begin
                        cnt_d = cnt_q + BL_W'(1);
                    end
                end
            end
            S_ZWR: begin
                if (axi_done) state_d = S_FBWR;
            end
            S_FBWR: begin
                if (axi_done) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (cur_x_q <= {1'b0, x2_q}) begin
                    state_d    = S_ZRD;
                    load_burst = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Burst size and start addresses captured on entry to ZRD
        if (load_burst) begin
            rem_px     = {1'b0, x2_d} - cur_x_d + XC_W'(1);
            chunk_d    = (rem_px >= XC_W'(BURST_LEN)) ? BL_W'(BURST_LEN) : BL_W'(rem_px);
            pix        = 32'(y_d) * 32'(ROW_PITCH) + 32'(cur_x_d);
            zb_burst_d = zb_base_d + pix * 32'(Z_W / 8);
            fb_burst_d = fb_base_d + pix * 32'(PIX_BYTES);
        end

        rd_req_d = (state_d == S_ZRD);
        wr_req_d = (state_d == S_ZWR) || (state_d == S_FBWR);
        wr_sel_d = (state_d == S_FBWR);
        case (state_d)
            S_ZRD, S_ZWR: begin
                addr_d      = zb_burst_d;
                burst_len_d = chunk_d;
            end
            S_FBWR: begin
                addr_d      = fb_burst_d;
                burst_len_d = chunk_d;
            end
            default: ;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            wr_sel_q    <= 1'b0;
            addr_q      <= '0;
            burst_len_q <= '0;
            fb_base_q   <= '0;
            zb_base_q   <= '0;
            zb_burst_q  <= '0;
            fb_burst_q  <= '0;
            y_q         <= '0;
            x2_q        <= '0;
            dx_q        <= '0;
            slope_q     <= '0;
            rem_q       <= '0;
            mode_q      <= '0;
            cur_x_q     <= '0;
            z_cur_q     <= '0;
            e_q         <= '0;
            cnt_q       <= '0;
            chunk_q     <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_req_q    <= rd_req_d;
            wr_req_q    <= wr_req_d;
            wr_sel_q    <= wr_sel_d;
            addr_q      <= addr_d;
            burst_len_q <= burst_len_d;
            fb_base_q   <= fb_base_d;
            zb_base_q   <= zb_base_d;
            zb_burst_q  <= zb_burst_d;
            fb_burst_q  <= fb_burst_d;
            y_q         <= y_d;
            x2_q        <= x2_d;
            dx_q        <= dx_d;
            slope_q     <= slope_d;
            rem_q       <= rem_d;
            mode_q      <= mode_d;
            cur_x_q     <= cur_x_d;
            z_cur_q     <= z_cur_d;
            e_q         <= e_d;
            cnt_q       <= cnt_d;
            chunk_q     <= chunk_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign rd_req       = rd_req_q;
    assign wr_req       = wr_req_q;
    assign wr_sel       = wr_sel_q;
    assign addr         = addr_q;
    assign burst_len    = burst_len_q;
    // FIFO strobes and write data follow the same-cycle accept decision
    assign read_zfifo   = push_c;
    assign write_zfifo  = push_c;
    assign write_befifo = push_c;
    assign z_out        = push_c ? (pass_c ? z_cur_q : zfifo_in) : '0;
    assign be_out       = (push_c && pass_c) ? '1 : '0;

`ifdef HLINE_ZSTATS_EN
    logic [X_W:0] pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;

    // Saturating per-pixel pass/fail counters, cleared on accepted start
    always_comb begin
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        if ((state_q == S_IDLE) && start) begin
            pass_cnt_d = '0;
            fail_cnt_d = '0;
        end else if (push_c) begin
            if (pass_c) begin
                if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + XC_W'(1);
            end else begin
                if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + XC_W'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;
`endif

endmodule

// File: tb/tb_hline_zspan_engine.sv
// Directed testbench for hline_zspan_engine with an AXI/FIFO responder and a
// reference span model. Define HLINE_ZSTATS_EN to also check the counters.
module tb_hline_zspan_engine;

    logic        clk, nreset, start, busy, done;
    logic [31:0] fb_addr, zbuff_addr;
    logic [15:0] y, x1, x2;
    logic [31:0] z1, slope, rem, err;
    logic [1:0]  cmp_mode;
    logic        rd_req, wr_req, wr_sel;
    logic [31:0] addr;
    logic [3:0]  burst_len;
    logic        axi_done, zread_empty, zfull, befull;
    logic [31:0] zfifo_in;
    logic        read_zfifo, write_zfifo, write_befifo;
    logic [31:0] z_out;
    logic [1:0]  be_out;
`ifdef HLINE_ZSTATS_EN
    logic [16:0] pass_cnt, fail_cnt;
`endif

    hline_zspan_engine dut (
        .clk(clk), .nreset(nreset), .start(start), .busy(busy), .done(done),
        .fb_addr(fb_addr), .zbuff_addr(zbuff_addr), .y(y), .x1(x1), .x2(x2),
        .z1(z1), .slope(slope), .rem(rem), .err(err), .cmp_mode(cmp_mode),
        .rd_req(rd_req), .wr_req(wr_req), .wr_sel(wr_sel), .addr(addr),
        .burst_len(burst_len), .axi_done(axi_done), .zread_empty(zread_empty),
        .zfifo_in(zfifo_in), .read_zfifo(read_zfifo), .zfull(zfull), .befull(befull),
        .write_zfifo(write_zfifo), .write_befifo(write_befifo), .z_out(z_out),
        .be_out(be_out)
`ifdef HLINE_ZSTATS_EN
        , .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
`endif
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          bp_err = 0;
    int          both_err = 0;
    bit          stall_en = 0;
    logic [31:0] zold_val = 32'h0;

    logic [31:0] cap_z[$];
    logic [1:0]  cap_be[$];
    int          log_kind[$];
    logic [31:0] log_addr[$];
    int          log_len[$];
    logic [31:0] exp_z[$];
    logic [1:0]  exp_be[$];
    int          exp_kind[$];
    logic [31:0] exp_addr[$];
    int          exp_len[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Memory-side responder: completes each request after 3 cycles, drives the
    // read FIFO, optionally stalls, and captures bursts and pushed pixels.
    initial begin : responder
        int req_cyc;
        req_cyc     = 0;
        axi_done    = 1'b0;
        zread_empty = 1'b0;
        zfull       = 1'b0;
        befull      = 1'b0;
        zfifo_in    = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            axi_done = 1'b0;
            if (rd_req || wr_req) begin
                req_cyc++;
                if (req_cyc == 3) begin
                    axi_done = 1'b1;
                    req_cyc  = 0;
                    log_kind.push_back(rd_req ? 0 : (wr_sel ? 2 : 1));
                    log_addr.push_back(addr);
                    log_len.push_back(int'(burst_len));
                end
            end else begin
                req_cyc = 0;
            end
            if (stall_en) begin
                zread_empty = ($urandom_range(0, 2) == 0);
                befull      = ($urandom_range(0, 3) == 0);
            end else begin
                zread_empty = 1'b0;
                befull      = 1'b0;
            end
            zfifo_in = zold_val;
            @(negedge clk);
            if (rd_req && wr_req) both_err++;
            if (write_zfifo || read_zfifo || write_befifo) begin
                if (!(write_zfifo && read_zfifo && write_befifo)) bp_err++;
                if (zread_empty || befull || zfull) bp_err++;
                if (write_zfifo) begin
                    cap_z.push_back(z_out);
                    cap_be.push_back(be_out);
                end
            end
        end
    end

    // Reference span: burst list and per-pixel compare results
    task automatic model(input int tx1, input int tx2, input int ty,
                         input logic [31:0] tz1, input logic [31:0] tslope,
                         input logic [31:0] trem, input logic [31:0] terr,
                         input logic [31:0] tfb, input logic [31:0] tzb,
                         input logic [1:0] mode);
        logic [31:0] z;
        int e, t, dx, n, p;
        bit pass;
        exp_z.delete(); exp_be.delete();
        exp_kind.delete(); exp_addr.delete(); exp_len.delete();
        if (tx1 > tx2) return;
        dx = tx2 - tx1;
        z  = tz1;
        e  = int'(terr);
        for (int x = tx1; x <= tx2; x += 8) begin
            n = (tx2 - x + 1 < 8) ? (tx2 - x + 1) : 8;
            p = ty * 640 + x;
            exp_kind.push_back(0); exp_addr.push_back(tzb + 32'(p) * 32'd4); exp_len.push_back(n);
            exp_kind.push_back(1); exp_addr.push_back(tzb + 32'(p) * 32'd4); exp_len.push_back(n);
            exp_kind.push_back(2); exp_addr.push_back(tfb + 32'(p) * 32'd2); exp_len.push_back(n);
        end
        for (int x = tx1; x <= tx2; x++) begin
            case (mode)
                2'd0:    pass = (z < zold_val);
                2'd1:    pass = (z <= zold_val);
                2'd2:    pass = 1'b1;
                default: pass = 1'b0;
            endcase
            exp_z.push_back(pass ? z : zold_val);
            exp_be.push_back(pass ? 2'b11 : 2'b00);
            t = e - int'(trem);
            if (t < 0) begin
                z = z + tslope + 32'd1;
                e = t + dx;
            end else begin
                z = z + tslope;
                e = t;
            end
        end
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_npix"}, 64'(cap_z.size()), 64'(exp_z.size()));
        for (int i = 0; i < exp_z.size(); i++) begin
            chk($sformatf("%s_z%0d", tag, i), 64'(cap_z[i]), 64'(exp_z[i]));
            chk($sformatf("%s_be%0d", tag, i), 64'(cap_be[i]), 64'(exp_be[i]));
        end
        chk({tag, "_nburst"}, 64'(log_kind.size()), 64'(exp_kind.size()));
        for (int i = 0; i < exp_kind.size(); i++) begin
            chk($sformatf("%s_kind%0d", tag, i), 64'(log_kind[i]), 64'(exp_kind[i]));
            chk($sformatf("%s_addr%0d", tag, i), 64'(log_addr[i]), 64'(exp_addr[i]));
            chk($sformatf("%s_len%0d", tag, i), 64'(log_len[i]), 64'(exp_len[i]));
        end
    endtask

    task automatic launch(input logic [15:0] ty, input logic [15:0] tx1, input logic [15:0] tx2,
                          input logic [31:0] tz1, input logic [31:0] tslope,
                          input logic [31:0] trem, input logic [31:0] terr,
                          input logic [31:0] tfb, input logic [31:0] tzb,
                          input logic [1:0] mode);
        cap_z.delete(); cap_be.delete();
        log_kind.delete(); log_addr.delete(); log_len.delete();
        y = ty; x1 = tx1; x2 = tx2; z1 = tz1; slope = tslope; rem = trem; err = terr;
        fb_addr = tfb; zbuff_addr = tzb; cmp_mode = mode;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            if (done) got = 1'b1;
            else @(negedge clk);
        end
        chk({tag, "_done"}, 64'(got), 64'd1);
        @(negedge clk);
        chk({tag, "_busy_clr"}, 64'(busy), 64'd0);
    endtask

    initial begin : main
        bit seen;
        nreset = 1'b0; start = 1'b0;
        fb_addr = '0; zbuff_addr = '0; y = '0; x1 = '0; x2 = '0;
        z1 = '0; slope = '0; rem = '0; err = '0; cmp_mode = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", 64'({busy, done, rd_req, wr_req, wr_sel, burst_len, write_zfifo}), 64'd0);
        chk("reset_addr", 64'(addr), 64'd0);
        nreset = 1'b1;
        @(negedge clk);

        // Two-burst LESS
        zold_val = 32'h8000_0000;
        launch(16'd2, 16'd0, 16'd15, 32'h0, 32'h1000_0000, 32'd0, 32'd8, 32'h0, 32'h1000_0000, 2'b00);
        chk("less_busy", 64'(busy), 64'd1);
        wait_done("less");
        chk("less_b0_addr", 64'(log_addr[0]), 64'h1000_1400);
        chk("less_b0_len", 64'(log_len[0]), 64'd8);
        chk("less_b2_fb", 64'(log_addr[2]), 64'h0000_0A00);
        chk("less_b3_addr", 64'(log_addr[3]), 64'h1000_1420);
        chk("less_b5_fb", 64'(log_addr[5]), 64'h0000_0A10);
        chk("less_z3", 64'(cap_z[3]), 64'h3000_0000);
        chk("less_be7", 64'(cap_be[7]), 64'd3);
        chk("less_z8", 64'(cap_z[8]), 64'h8000_0000);
        chk("less_be8", 64'(cap_be[8]), 64'd0);
`ifdef HLINE_ZSTATS_EN
        chk("stats_pass", 64'(pass_cnt), 64'd8);
        chk("stats_fail", 64'(fail_cnt), 64'd8);
`endif
        model(0, 15, 2, 32'h0, 32'h1000_0000, 32'd0, 32'd8, 32'h0, 32'h1000_0000, 2'b00);
        cmp_stream("less");

        // LEQUAL: pixel 8 ties and passes
        launch(16'd2, 16'd0, 16'd15, 32'h0, 32'h1000_0000, 32'd0, 32'd8, 32'h0, 32'h1000_0000, 2'b01);
        wait_done("leq");
        chk("leq_be8", 64'(cap_be[8]), 64'd3);
        chk("leq_z8", 64'(cap_z[8]), 64'h8000_0000);
        chk("leq_be9", 64'(cap_be[9]), 64'd0);

        // Carry through the remainder accumulator, 33 bursts
        zold_val = 32'hFFFF_FFFF;
        launch(16'd0, 16'd0, 16'd256, 32'h0, 32'h00FF_FFFF, 32'd255, 32'd128, 32'h0, 32'h0, 2'b01);
        wait_done("carry");
        chk("carry_z1", 64'(cap_z[1]), 64'h0100_0000);
        chk("carry_zlast", 64'(cap_z[256]), 64'hFFFF_FFFF);
        chk("carry_belast", 64'(cap_be[256]), 64'd3);
        chk("carry_nburst", 64'(log_kind.size()), 64'd99);
        chk("carry_lastlen", 64'(log_len[96]), 64'd1);
        chk("carry_lastaddr", 64'(log_addr[96]), 64'h400);
        model(0, 256, 0, 32'h0, 32'h00FF_FFFF, 32'd255, 32'd128, 32'h0, 32'h0, 2'b01);
        cmp_stream("carry");

        // Partial span
        zold_val = 32'h8000_0000;
        launch(16'd0, 16'd5, 16'd7, 32'h10, 32'h1, 32'd0, 32'd0, 32'h200, 32'h100, 2'b10);
        wait_done("part");
        chk("part_nburst", 64'(log_kind.size()), 64'd3);
        chk("part_len", 64'(log_len[0]), 64'd3);
        chk("part_zaddr", 64'(log_addr[0]), 64'h114);
        chk("part_fbaddr", 64'(log_addr[2]), 64'h20A);
        chk("part_z2", 64'(cap_z[2]), 64'h12);

        // Degenerate x1>x2
        launch(16'd0, 16'd9, 16'd3, 32'h0, 32'h0, 32'd0, 32'd0, 32'h0, 32'h0, 2'b00);
        chk("degen_done_early", 64'(done), 64'd0);
        @(negedge clk);
        chk("degen_done", 64'(done), 64'd1);
        chk("degen_busy", 64'(busy), 64'd0);
        repeat (4) @(negedge clk);
        chk("degen_noreq", 64'(log_kind.size()), 64'd0);
        chk("degen_nopix", 64'(cap_z.size()), 64'd0);

        // Backpressure on read FIFO and byte-enable FIFO
        stall_en = 1'b1;
        launch(16'd2, 16'd0, 16'd15, 32'h0, 32'h1000_0000, 32'd0, 32'd8, 32'h0, 32'h1000_0000, 2'b00);
        wait_done("bp");
        stall_en = 1'b0;
        model(0, 15, 2, 32'h0, 32'h1000_0000, 32'd0, 32'd8, 32'h0, 32'h1000_0000, 2'b00);
        cmp_stream("bp");
        chk("bp_strobes", 64'(bp_err), 64'd0);

        // Asynchronous reset during the z-buffer write burst
        launch(16'd2, 16'd0, 16'd15, 32'h0, 32'h1000_0000, 32'd0, 32'd8, 32'h0, 32'h1000_0000, 2'b00);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (wr_req && !wr_sel) seen = 1'b1;
            else @(negedge clk);
        end
        chk("rst_reached_zwr", 64'(seen), 64'd1);
        #2 nreset = 1'b0;
        #1;
        chk("rst_outs", 64'({busy, done, rd_req, wr_req, wr_sel, burst_len, write_zfifo, be_out}), 64'd0);
        chk("rst_addr", 64'(addr), 64'd0);
        @(negedge clk);
        nreset = 1'b1;
        repeat (2) @(negedge clk);

        // Fresh start after reset, NEVER mode
        launch(16'd1, 16'd3, 16'd12, 32'h5, 32'h100, 32'd3, 32'd1, 32'h40, 32'h80, 2'b11);
        wait_done("never");
        chk("never_be0", 64'(cap_be[0]), 64'd0);
        chk("never_z0", 64'(cap_z[0]), 64'h8000_0000);
        model(3, 12, 1, 32'h5, 32'h100, 32'd3, 32'd1, 32'h40, 32'h80, 2'b11);
        cmp_stream("never");

        chk("req_exclusive", 64'(both_err), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
